// File: rtl/ahbl_arbiter.sv
// ahbl_arbiter: N-master to 1-slave AHB-Lite arbiter.
// Each upstream port looks like an AHB-Lite slave to its master. An address
// phase that is not issued downstream is parked in a per-port buffer, and
// the master is stalled through its own hready until the buffered transfer
// completes.
// Optional macro AHBL_ARBITER_ROUND_ROBIN_EN selects rotating priority.
// Without it, priority is fixed and the lowest port index wins.
module ahbl_arbiter #(
    parameter int N_PORTS = 2,
    parameter int W_ADDR  = 32,
    parameter int W_DATA  = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_PORTS*W_ADDR-1:0] src_haddr,
    input  logic [N_PORTS-1:0]        src_hwrite,
    input  logic [N_PORTS-1:0]        src_hmastlock,
    input  logic [N_PORTS*2-1:0]      src_htrans,
    input  logic [N_PORTS*3-1:0]      src_hsize,
    input  logic [N_PORTS*3-1:0]      src_hburst,
    input  logic [N_PORTS*4-1:0]      src_hprot,
    input  logic [N_PORTS*W_DATA-1:0] src_hwdata,
    output logic [N_PORTS-1:0]        src_hready,
    output logic [N_PORTS-1:0]        src_hresp,
    output logic [N_PORTS*W_DATA-1:0] src_hrdata,
    output logic [W_ADDR-1:0]         dst_haddr,
    output logic                      dst_hwrite,
    output logic [1:0]                dst_htrans,
    output logic [2:0]                dst_hsize,
    output logic [2:0]                dst_hburst,
    output logic [3:0]                dst_hprot,
    output logic                      dst_hmastlock,
    output logic [W_DATA-1:0]         dst_hwdata,
    output logic                      dst_hready,
    input  logic                      dst_hready_resp,
    input  logic                      dst_hresp,
    input  logic [W_DATA-1:0]         dst_hrdata
);

    localparam int W_IDX = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef struct packed {
        logic [W_ADDR-1:0] haddr;
        logic              hwrite;
        logic [1:0]        htrans;
        logic [2:0]        hsize;
        logic [2:0]        hburst;
        logic [3:0]        hprot;
        logic              hmastlock;
    } aph_t;

    aph_t               live_aph [N_PORTS];
    aph_t               buf_aph  [N_PORTS];
    aph_t               sel_aph;
    aph_t               last_aph;
    aph_t               dst_aph;
    logic [N_PORTS-1:0] buf_vld;
    logic [N_PORTS-1:0] live;
    logic [N_PORTS-1:0] pending;
    logic [W_IDX-1:0]   winner;
    logic [W_IDX-1:0]   lock_port;
    logic [W_IDX-1:0]   dph_port;
    logic               grant_vld;
    logic               lock_active;
    logic               dph_vld;
    logic               issue;

`ifdef AHBL_ARBITER_ROUND_ROBIN_EN
    logic [W_IDX-1:0]   rr_ptr;
`endif

    // Unpack the flat per-port buses into one address-phase record per port
    always_comb begin
        for (int i = 0; i < N_PORTS; i++) begin
            live_aph[i].haddr     = src_haddr[i*W_ADDR +: W_ADDR];
            live_aph[i].hwrite    = src_hwrite[i];
            live_aph[i].htrans    = src_htrans[i*2 +: 2];
            live_aph[i].hsize     = src_hsize[i*3 +: 3];
            live_aph[i].hburst    = src_hburst[i*3 +: 3];
            live_aph[i].hprot     = src_hprot[i*4 +: 4];
            live_aph[i].hmastlock = src_hmastlock[i];
        end
    end

    // Per-port ready/response: data-phase owner sees the slave, a buffered port is stalled
    always_comb begin
        for (int i = 0; i < N_PORTS; i++) begin
            src_hready[i] = 1'b1;
            src_hresp[i]  = 1'b0;
            if (dph_vld && dph_port == W_IDX'(i)) begin
                src_hready[i] = dst_hready_resp;
                src_hresp[i]  = dst_hresp;
            end else if (buf_vld[i]) begin
                src_hready[i] = 1'b0;
            end
        end
    end

    // A port requests when it has a buffered phase or a fresh transfer this cycle
    always_comb begin
        for (int i = 0; i < N_PORTS; i++) begin
            live[i]    = src_htrans[i*2+1] && src_hready[i] && !buf_vld[i];
            pending[i] = buf_vld[i] || live[i];
        end
    end

    // Pick the winner: a locked owner keeps the bus, otherwise priority search
    always_comb begin
        winner    = '0;
        grant_vld = 1'b0;
        if (lock_active) begin
            winner    = lock_port;
            grant_vld = pending[lock_port];
        end else begin
`ifdef AHBL_ARBITER_ROUND_ROBIN_EN
            for (int k = N_PORTS - 1; k >= 0; k--) begin
                if (pending[(int'(rr_ptr) + k) % N_PORTS]) begin
                    winner    = W_IDX'((int'(rr_ptr) + k) % N_PORTS);
                    grant_vld = 1'b1;
                end
            end
`else
            for (int i = N_PORTS - 1; i >= 0; i--) begin
                if (pending[i]) begin
                    winner    = W_IDX'(i);
                    grant_vld = 1'b1;
                end
            end
`endif
        end
    end

    // Route the winner's address phase (buffered copy first) to the slave
    always_comb begin
        sel_aph = buf_vld[winner] ? buf_aph[winner] : live_aph[winner];
        dst_aph = grant_vld ? sel_aph : last_aph;
        issue   = dst_hready_resp && grant_vld;
    end

    assign dst_haddr     = dst_aph.haddr;
    assign dst_hwrite    = dst_aph.hwrite;
    assign dst_htrans    = dst_aph.htrans;
    assign dst_hsize     = dst_aph.hsize;
    assign dst_hburst    = dst_aph.hburst;
    assign dst_hprot     = dst_aph.hprot;
    assign dst_hmastlock = dst_aph.hmastlock;
    assign dst_hready    = dst_hready_resp;
    assign dst_hwdata    = src_hwdata[dph_port*W_DATA +: W_DATA];
    assign src_hrdata    = {N_PORTS{dst_hrdata}};

    // Capture live requests that are not issued; release a buffer once it is issued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_vld <= '0;
            for (int i = 0; i < N_PORTS; i++) begin
                buf_aph[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_PORTS; i++) begin
                if (buf_vld[i]) begin
                    if (issue && winner == W_IDX'(i)) begin
                        buf_vld[i] <= 1'b0;
                    end
                end else if (live[i] && !(issue && winner == W_IDX'(i))) begin
                    buf_vld[i] <= 1'b1;
                    buf_aph[i] <= live_aph[i];
                end
            end
        end
    end

    // Track the data-phase owner and remember the last issued address for idle cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dph_vld  <= 1'b0;
            dph_port <= '0;
            last_aph <= '0;
        end else if (dst_hready_resp) begin
            dph_vld  <= grant_vld && sel_aph.htrans[1];
            dph_port <= winner;
            if (grant_vld) begin
                last_aph        <= sel_aph;
                last_aph.htrans <= HTRANS_IDLE;
            end
        end
    end

    // Hold the grant on a port while its issued phases carry hmastlock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_active <= 1'b0;
            lock_port   <= '0;
        end else if (dst_hready_resp) begin
            if (grant_vld) begin
                lock_active <= sel_aph.hmastlock;
                lock_port   <= winner;
            end else begin
                lock_active <= lock_active && src_hmastlock[lock_port];
            end
        end
    end

`ifdef AHBL_ARBITER_ROUND_ROBIN_EN
    // Rotate the search start past the winner of each unlocked NONSEQ issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (issue && sel_aph.htrans == HTRANS_NONSEQ && !lock_active && !sel_aph.hmastlock) begin
            rr_ptr <= (winner == W_IDX'(N_PORTS - 1)) ? '0 : winner + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ahbl_arbiter.sv
// tb_ahbl_arbiter: directed test of ahbl_arbiter with two upstream ports.
// The rotating-grant sequence is only exercised when the design is built
// with AHBL_ARBITER_ROUND_ROBIN_EN.
module tb_ahbl_arbiter;

    localparam int N_PORTS = 2;
    localparam int W_ADDR  = 32;
    localparam int W_DATA  = 32;
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [31:0] WDATA0 = 32'hD0D0_0000;
    localparam logic [31:0] WDATA1 = 32'hD1D1_1111;

    logic                      clk;
    logic                      rst_n;
    logic [N_PORTS*W_ADDR-1:0] src_haddr;
    logic [N_PORTS-1:0]        src_hwrite;
    logic [N_PORTS-1:0]        src_hmastlock;
    logic [N_PORTS*2-1:0]      src_htrans;
    logic [N_PORTS*3-1:0]      src_hsize;
    logic [N_PORTS*3-1:0]      src_hburst;
    logic [N_PORTS*4-1:0]      src_hprot;
    logic [N_PORTS*W_DATA-1:0] src_hwdata;
    logic [N_PORTS-1:0]        src_hready;
    logic [N_PORTS-1:0]        src_hresp;
    logic [N_PORTS*W_DATA-1:0] src_hrdata;
    logic [W_ADDR-1:0]         dst_haddr;
    logic                      dst_hwrite;
    logic [1:0]                dst_htrans;
    logic [2:0]                dst_hsize;
    logic [2:0]                dst_hburst;
    logic [3:0]                dst_hprot;
    logic                      dst_hmastlock;
    logic [W_DATA-1:0]         dst_hwdata;
    logic                      dst_hready;
    logic                      dst_hready_resp;
    logic                      dst_hresp;
    logic [W_DATA-1:0]         dst_hrdata;

    int total;
    int bad;
    int found;

    ahbl_arbiter #(
        .N_PORTS(N_PORTS),
        .W_ADDR (W_ADDR),
        .W_DATA (W_DATA)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .src_haddr      (src_haddr),
        .src_hwrite     (src_hwrite),
        .src_hmastlock  (src_hmastlock),
        .src_htrans     (src_htrans),
        .src_hsize      (src_hsize),
        .src_hburst     (src_hburst),
        .src_hprot      (src_hprot),
        .src_hwdata     (src_hwdata),
        .src_hready     (src_hready),
        .src_hresp      (src_hresp),
        .src_hrdata     (src_hrdata),
        .dst_haddr      (dst_haddr),
        .dst_hwrite     (dst_hwrite),
        .dst_htrans     (dst_htrans),
        .dst_hsize      (dst_hsize),
        .dst_hburst     (dst_hburst),
        .dst_hprot      (dst_hprot),
        .dst_hmastlock  (dst_hmastlock),
        .dst_hwdata     (dst_hwdata),
        .dst_hready     (dst_hready),
        .dst_hready_resp(dst_hready_resp),
        .dst_hresp      (dst_hresp),
        .dst_hrdata     (dst_hrdata)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] time limit reached");
    end

    // Drive one master's address-phase signals
    task automatic applyStimulus(input int p, input logic [1:0] trans, input logic [31:0] addr,
                                 input logic write, input logic lock);
        src_htrans[p*2 +: 2]      = trans;
        src_haddr[p*W_ADDR +: 32] = addr;
        src_hwrite[p]             = write;
        src_hmastlock[p]          = lock;
    endtask

    // Compare one observed value with its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Return every input to idle and pulse reset for two cycles
    task automatic applyReset();
        rst_n = 1'b0;
        applyStimulus(0, IDLE, 32'h0, 1'b0, 1'b0);
        applyStimulus(1, IDLE, 32'h0, 1'b0, 1'b0);
        dst_hready_resp = 1'b1;
        dst_hresp       = 1'b0;
        dst_hrdata      = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Directed sequence
    initial begin
        total           = 0;
        bad             = 0;
        found           = 0;
        rst_n           = 1'b0;
        src_haddr       = '0;
        src_hwrite      = '0;
        src_hmastlock   = '0;
        src_htrans      = '0;
        src_hsize       = {3'd2, 3'd2};
        src_hburst      = '0;
        src_hprot       = {4'd3, 4'd3};
        src_hwdata      = {WDATA1, WDATA0};
        dst_hready_resp = 1'b1;
        dst_hresp       = 1'b0;
        dst_hrdata      = '0;

        // Reset state
        #3;
        checkOutput("rst_hready", src_hready, 2'b11);
        checkOutput("rst_hresp", src_hresp, 2'b00);
        checkOutput("rst_htrans", dst_htrans, IDLE);
        checkOutput("rst_haddr", dst_haddr, 32'h0);
        checkOutput("rst_hwrite", dst_hwrite, 1'b0);
        checkOutput("rst_hmastlock", dst_hmastlock, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Port 0 alone: read 0x100 passes straight through
        @(negedge clk);
        applyStimulus(0, NONSEQ, 32'h100, 1'b0, 1'b0);
        #1;
        checkOutput("t1_htrans", dst_htrans, NONSEQ);
        checkOutput("t1_haddr", dst_haddr, 32'h100);
        checkOutput("t1_hready0_a", src_hready[0], 1'b1);
        @(negedge clk);
        applyStimulus(0, IDLE, 32'h0, 1'b0, 1'b0);
        dst_hrdata = 32'hCAFEF00D;
        #1;
        checkOutput("t1_rdata0", src_hrdata[31:0], 32'hCAFEF00D);
        checkOutput("t1_rdata1", src_hrdata[63:32], 32'hCAFEF00D);
        checkOutput("t1_hready_d", src_hready, 2'b11);
        checkOutput("t1_hresp", src_hresp, 2'b00);
        checkOutput("t1_idle", dst_htrans, IDLE);
        checkOutput("t1_hold_addr", dst_haddr, 32'h100);

        // Both ports write in the same cycle: port 0 first, port 1 buffered one cycle
        applyReset();
        @(negedge clk);
        applyStimulus(0, NONSEQ, 32'h10, 1'b1, 1'b0);
        applyStimulus(1, NONSEQ, 32'h20, 1'b1, 1'b0);
        #1;
        checkOutput("t2_addr_a", dst_haddr, 32'h10);
        checkOutput("t2_trans_a", dst_htrans, NONSEQ);
        checkOutput("t2_hready_a", src_hready, 2'b11);
        @(negedge clk);
        applyStimulus(0, IDLE, 32'h0, 1'b0, 1'b0);
        applyStimulus(1, IDLE, 32'h0, 1'b0, 1'b0);
        #1;
        checkOutput("t2_addr_b", dst_haddr, 32'h20);
        checkOutput("t2_trans_b", dst_htrans, NONSEQ);
        checkOutput("t2_write_b", dst_hwrite, 1'b1);
        checkOutput("t2_hready_b", src_hready, 2'b01);
        checkOutput("t2_wdata_b", dst_hwdata, WDATA0);
        @(negedge clk);
        #1;
        checkOutput("t2_hready_c", src_hready, 2'b11);
        checkOutput("t2_wdata_c", dst_hwdata, WDATA1);
        checkOutput("t2_trans_c", dst_htrans, IDLE);

        // Slave waits twice on port 0 while port 1 requests
        applyReset();
        @(negedge clk);
        applyStimulus(0, NONSEQ, 32'h200, 1'b0, 1'b0);
        #1;
        checkOutput("t3_addr_a", dst_haddr, 32'h200);
        @(negedge clk);
        applyStimulus(0, IDLE, 32'h0, 1'b0, 1'b0);
        applyStimulus(1, NONSEQ, 32'h300, 1'b0, 1'b0);
        dst_hready_resp = 1'b0;
        #1;
        checkOutput("t3_hready_b", src_hready, 2'b10);
        checkOutput("t3_addr_b", dst_haddr, 32'h300);
        @(negedge clk);
        applyStimulus(1, IDLE, 32'h0, 1'b0, 1'b0);
        #1;
        checkOutput("t3_hready_c", src_hready, 2'b00);
        checkOutput("t3_addr_c", dst_haddr, 32'h300);
        checkOutput("t3_trans_c", dst_htrans, NONSEQ);
        @(negedge clk);
        dst_hready_resp = 1'b1;
        dst_hrdata      = 32'h1111_2222;
        #1;
        checkOutput("t3_hready_d", src_hready, 2'b01);
        checkOutput("t3_rdata_d", src_hrdata[31:0], 32'h1111_2222);
        checkOutput("t3_addr_d", dst_haddr, 32'h300);
        checkOutput("t3_trans_d", dst_htrans, NONSEQ);
        @(negedge clk);
        dst_hrdata = 32'h3333_4444;
        #1;
        checkOutput("t3_hready_e", src_hready, 2'b11);
        checkOutput("t3_trans_e", dst_htrans, IDLE);
        @(negedge clk);
        #1;
        checkOutput("t3_nodup_f", dst_htrans, IDLE);

        // Locked read then write on port 1 keeps port 0 out
        applyReset();
        @(negedge clk);
        applyStimulus(1, NONSEQ, 32'h40, 1'b0, 1'b1);
        #1;
        checkOutput("t4_addr_a", dst_haddr, 32'h40);
        checkOutput("t4_write_a", dst_hwrite, 1'b0);
        checkOutput("t4_lock_a", dst_hmastlock, 1'b1);
        @(negedge clk);
        applyStimulus(1, NONSEQ, 32'h40, 1'b1, 1'b1);
        applyStimulus(0, NONSEQ, 32'h80, 1'b0, 1'b0);
        #1;
        checkOutput("t4_addr_b", dst_haddr, 32'h40);
        checkOutput("t4_write_b", dst_hwrite, 1'b1);
        checkOutput("t4_lock_b", dst_hmastlock, 1'b1);
        @(negedge clk);
        applyStimulus(1, IDLE, 32'h0, 1'b0, 1'b0);
        applyStimulus(0, IDLE, 32'h0, 1'b0, 1'b0);
        #1;
        checkOutput("t4_hready0_c", src_hready[0], 1'b0);
        checkOutput("t4_wdata_c", dst_hwdata, WDATA1);
        found = (dst_htrans == NONSEQ && dst_haddr == 32'h80) ? 1 : 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            if (dst_htrans == NONSEQ && dst_haddr == 32'h80) found++;
        end
        checkOutput("t4_p0_issued_once", found, 1);
        checkOutput("t4_hready_end", src_hready, 2'b11);

        // Error on port 0 data phase while port 1 is buffered
        applyReset();
        @(negedge clk);
        applyStimulus(0, NONSEQ, 32'h500, 1'b0, 1'b0);
        #1;
        checkOutput("t5_addr_a", dst_haddr, 32'h500);
        @(negedge clk);
        applyStimulus(0, IDLE, 32'h0, 1'b0, 1'b0);
        applyStimulus(1, NONSEQ, 32'h600, 1'b0, 1'b0);
        dst_hready_resp = 1'b0;
        dst_hresp       = 1'b1;
        #1;
        checkOutput("t5_hresp_b", src_hresp, 2'b01);
        checkOutput("t5_hready_b", src_hready, 2'b10);
        @(negedge clk);
        applyStimulus(1, IDLE, 32'h0, 1'b0, 1'b0);
        dst_hready_resp = 1'b1;
        #1;
        checkOutput("t5_hresp_c", src_hresp, 2'b01);
        checkOutput("t5_hready_c", src_hready, 2'b01);
        checkOutput("t5_addr_c", dst_haddr, 32'h600);
        checkOutput("t5_trans_c", dst_htrans, NONSEQ);
        @(negedge clk);
        dst_hresp = 1'b0;
        #1;
        checkOutput("t5_hresp_d", src_hresp, 2'b00);
        checkOutput("t5_hready_d", src_hready, 2'b11);
        checkOutput("t5_trans_d", dst_htrans, IDLE);

`ifdef AHBL_ARBITER_ROUND_ROBIN_EN
        // Both ports request continuously: grants alternate starting at port 0
        applyReset();
        begin
            logic [31:0] a0;
            logic [31:0] a1;
            logic [1:0]  rdy_prev;
            logic [2:0]  want;
            a0       = 32'h1000;
            a1       = 32'h2000;
            rdy_prev = 2'b00;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                if (rdy_prev[0]) a0 = a0 + 32'd4;
                if (rdy_prev[1]) a1 = a1 + 32'd4;
                applyStimulus(0, NONSEQ, a0, 1'b0, 1'b0);
                applyStimulus(1, NONSEQ, a1, 1'b0, 1'b0);
                #1;
                want = {NONSEQ, 1'b0};
                want[0] = (k % 2 == 1);
                checkOutput($sformatf("t6_grant%0d", k), {61'd0, dst_htrans, dst_haddr[13]}, {61'd0, want});
                rdy_prev = src_hready;
            end
        end
`endif

        // Reset while port 1 sits in its buffer
        applyReset();
        @(negedge clk);
        applyStimulus(0, NONSEQ, 32'h10, 1'b1, 1'b0);
        applyStimulus(1, NONSEQ, 32'h20, 1'b1, 1'b0);
        @(negedge clk);
        applyStimulus(0, NONSEQ, 32'h14, 1'b1, 1'b0);
        applyStimulus(1, IDLE, 32'h0, 1'b0, 1'b0);
        #1;
        checkOutput("t7_buffered", src_hready[1], 1'b0);
        #1;
        rst_n = 1'b0;
        applyStimulus(0, IDLE, 32'h0, 1'b0, 1'b0);
        #1;
        checkOutput("t7_rst_hready", src_hready, 2'b11);
        checkOutput("t7_rst_htrans", dst_htrans, IDLE);
        checkOutput("t7_rst_haddr", dst_haddr, 32'h0);
        checkOutput("t7_rst_hresp", src_hresp, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("t7_post_htrans", dst_htrans, IDLE);
        checkOutput("t7_post_hready", src_hready, 2'b11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
